wb_trace_buffer: RTL and testbench

Parametrised writeback trace capture for the pipelined RV32 core with split integer/FP register files. Snoops the W stage and records every architectural register write, tagged with cycle stamp and register file, into a circular buffer drained over a valid/ready port. It also counts F-stage stalls and E-stage flushes. It sits beside the hazard unit, so benches and on-chip debug can check FLW/FSW, forwarding and stall behaviour without hierarchical peeks.

---
 rtl/trace_pkg.sv | 23 ++
 rtl/trace_ring.sv | 65 ++++++
 rtl/wb_trace_buffer.sv | 103 ++++++++++
 tb/tb_wb_trace_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the writeback trace buffer.
// Entry layout, capture mode encoding and default widths.
package trace_pkg;

  localparam int XLEN = 32;
  localparam int CNTW = 16;

  typedef struct packed {
    logic [CNTW-1:0] stamp;
    logic            is_fp;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc;
  } trace_entry_t;

  typedef enum logic [1:0] {
    TR_ALL = 2'b00,
    TR_INT = 2'b01,
    TR_FP  = 2'b10,
    TR_OFF = 2'b11
  } trace_mode_e;

endpackage

// File: rtl/trace_ring.sv
// Circular store of trace entries with push/pop/overwrite/clear.
// Ports: clk, reset, clear, push, pop, wrap, din -> head, valid, count, drop.
module trace_ring
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic         wrap,
  input  trace_entry_t din,
  output trace_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count,
  output logic         drop
);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] hd;
  logic [AW-1:0] tl;
  logic          full;
  logic          do_pop;
  logic          wr;
  logic          adv;

  assign full   = (count == CW'(DEPTH));
  assign valid  = (count != '0);
  assign do_pop = pop & valid;

  // When full and not popping, a write only lands in wrap mode,
  // and then it pushes the head along with it.
  assign wr   = push & (~full | do_pop | wrap);
  assign adv  = do_pop | (push & full & ~do_pop & wrap);
  assign drop = push & full & ~do_pop;

  assign head = valid ? mem[hd] : '0;

  always_ff @(posedge clk) begin
    if (reset | clear) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (wr)
        tl <= tl + AW'(1);
      if (adv)
        hd <= hd + AW'(1);
      if (wr & ~adv)
        count <= count + CW'(1);
      else if (adv & ~wr)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (~reset & ~clear & wr)
      mem[tl] <= din;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// W-stage register-write tracer with stall/flush event counters.
// Ports: W-stage snoop, hazard inputs, config, valid/ready drain, counters.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     clear,
  input  logic [1:0]               cfg_mode,
  input  logic                     cfg_wrap,
  input  logic                     RegWriteW,
  input  logic                     useFP_RF_W,
  input  logic [4:0]               RdW,
  input  logic [XLEN-1:0]          ResultW,
  input  logic [XLEN-1:0]          PCW,
  input  logic                     StallF,
  input  logic                     FlushE,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CNTW-1:0]          rd_stamp,
  output logic                     rd_is_fp,
  output logic [4:0]               rd_rd,
  output logic [XLEN-1:0]          rd_result,
  output logic [XLEN-1:0]          rd_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNTW-1:0]          dropped,
  output logic [CNTW-1:0]          stall_cnt,
  output logic [CNTW-1:0]          flush_cnt
);

  logic [CNTW-1:0] cyc;
  trace_mode_e     mode;
  logic            match;
  logic            capture;
  logic            drop;
  trace_entry_t    din;
  trace_entry_t    head;

  assign mode = trace_mode_e'(cfg_mode);

  always_comb begin
    match = 1'b0;
    unique case (1'b1)
      mode == TR_ALL: match = 1'b1;
      mode == TR_INT: match = ~useFP_RF_W;
      mode == TR_FP:  match = useFP_RF_W;
      mode == TR_OFF: match = 1'b0;
    endcase
  end

  // x0 writes are architectural no-ops; f0 is a real register.
  assign capture = arm & RegWriteW & match
                 & ~(~useFP_RF_W & (RdW == 5'd0));

  assign din.stamp  = cyc;
  assign din.is_fp  = useFP_RF_W;
  assign din.rd     = RdW;
  assign din.result = ResultW;
  assign din.pc     = PCW;

  trace_ring #(.DEPTH(DEPTH)) u_ring (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (capture),
    .pop   (rd_ready),
    .wrap  (cfg_wrap),
    .din   (din),
    .head  (head),
    .valid (rd_valid),
    .count (count),
    .drop  (drop)
  );

  assign rd_stamp  = head.stamp;
  assign rd_is_fp  = head.is_fp;
  assign rd_rd     = head.rd;
  assign rd_result = head.result;
  assign rd_pc     = head.pc;

  always_ff @(posedge clk) begin
    if (reset | clear) begin
      cyc       <= '0;
      dropped   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc <= cyc + CNTW'(1);
      if (drop & ~&dropped)
        dropped <= dropped + CNTW'(1);
      if (StallF & ~&stall_cnt)
        stall_cnt <= stall_cnt + CNTW'(1);
      if (FlushE & ~&flush_cnt)
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer at DEPTH=4.
// Table of single-cycle vectors plus multi-cycle corner sequences.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset, arm, clear, cfg_wrap;
  logic [1:0]  cfg_mode;
  logic        RegWriteW, useFP_RF_W;
  logic [4:0]  RdW;
  logic [31:0] ResultW, PCW;
  logic        StallF, FlushE;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_stamp;
  logic        rd_is_fp;
  logic [4:0]  rd_rd;
  logic [31:0] rd_result, rd_pc;
  logic [2:0]  count;
  logic [15:0] dropped, stall_cnt, flush_cnt;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(4), .XLEN(32), .CNTW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .clear      (clear),
    .cfg_mode   (cfg_mode),
    .cfg_wrap   (cfg_wrap),
    .RegWriteW  (RegWriteW),
    .useFP_RF_W (useFP_RF_W),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .PCW        (PCW),
    .StallF     (StallF),
    .FlushE     (FlushE),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_stamp   (rd_stamp),
    .rd_is_fp   (rd_is_fp),
    .rd_rd      (rd_rd),
    .rd_result  (rd_result),
    .rd_pc      (rd_pc),
    .count      (count),
    .dropped    (dropped),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        we;
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] pc;
    logic        ready;
    logic        ev;
    logic        efp;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic [31:0] epc;
    logic [15:0] estamp;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic cap(input logic [31:0] v);
    RegWriteW  = 1'b1;
    useFP_RF_W = 1'b0;
    RdW        = 5'd5;
    ResultW    = v;
    PCW        = v << 2;
    tick();
    RegWriteW  = 1'b0;
  endtask

  task automatic drain(input string name, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      chk({name, "_valid"}, 64'(rd_valid), 64'd1);
      chk({name, "_val"}, 64'(rd_result), 64'(first + k));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    chk({name, "_empty"}, 64'(rd_valid), 64'd0);
  endtask

  initial begin
    vt[0]  = '{2'd0, 1, 1, 5'd1, 32'h3f400000, 32'h4, 0,
               1, 1, 5'd1, 32'h3f400000, 32'h4, 16'd0, 3'd1};
    vt[1]  = '{2'd0, 1, 0, 5'd2, 32'h8, 32'h8, 0,
               1, 1, 5'd1, 32'h3f400000, 32'h4, 16'd0, 3'd2};
    vt[2]  = '{2'd0, 0, 0, 5'd0, 32'h0, 32'h0, 1,
               1, 0, 5'd2, 32'h8, 32'h8, 16'd1, 3'd1};
    vt[3]  = '{2'd0, 0, 0, 5'd0, 32'h0, 32'h0, 1,
               0, 0, 5'd0, 32'h0, 32'h0, 16'd0, 3'd0};
    vt[4]  = '{2'd0, 1, 0, 5'd0, 32'hdeadbeef, 32'hc, 0,
               0, 0, 5'd0, 32'h0, 32'h0, 16'd0, 3'd0};
    vt[5]  = '{2'd0, 1, 1, 5'd0, 32'hbfc00000, 32'h10, 0,
               1, 1, 5'd0, 32'hbfc00000, 32'h10, 16'd5, 3'd1};
    vt[6]  = '{2'd0, 0, 0, 5'd0, 32'h0, 32'h0, 1,
               0, 0, 5'd0, 32'h0, 32'h0, 16'd0, 3'd0};
    vt[7]  = '{2'd2, 1, 0, 5'd10, 32'h11, 32'h14, 0,
               0, 0, 5'd0, 32'h0, 32'h0, 16'd0, 3'd0};
    vt[8]  = '{2'd2, 1, 1, 5'd10, 32'h40000000, 32'h18, 0,
               1, 1, 5'd10, 32'h40000000, 32'h18, 16'd8, 3'd1};
    vt[9]  = '{2'd2, 0, 0, 5'd0, 32'h0, 32'h0, 1,
               0, 0, 5'd0, 32'h0, 32'h0, 16'd0, 3'd0};
    vt[10] = '{2'd3, 1, 0, 5'd10, 32'h11, 32'h1c, 0,
               0, 0, 5'd0, 32'h0, 32'h0, 16'd0, 3'd0};
    vt[11] = '{2'd3, 1, 1, 5'd10, 32'h40000000, 32'h20, 0,
               0, 0, 5'd0, 32'h0, 32'h0, 16'd0, 3'd0};

    reset = 1'b1; arm = 1'b1; clear = 1'b0;
    cfg_mode = 2'd0; cfg_wrap = 1'b0;
    RegWriteW = 1'b0; useFP_RF_W = 1'b0; RdW = '0;
    ResultW = '0; PCW = '0; StallF = 1'b0; FlushE = 1'b0;
    rd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_result", 64'(rd_result), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cfg_mode   = vt[i].mode;
      RegWriteW  = vt[i].we;
      useFP_RF_W = vt[i].fp;
      RdW        = vt[i].rd;
      ResultW    = vt[i].res;
      PCW        = vt[i].pc;
      rd_ready   = vt[i].ready;
      tick();
      chk($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(vt[i].ev));
      chk($sformatf("v%0d_fp", i), 64'(rd_is_fp), 64'(vt[i].efp));
      chk($sformatf("v%0d_rd", i), 64'(rd_rd), 64'(vt[i].erd));
      chk($sformatf("v%0d_res", i), 64'(rd_result), 64'(vt[i].eres));
      chk($sformatf("v%0d_pc", i), 64'(rd_pc), 64'(vt[i].epc));
      chk($sformatf("v%0d_stamp", i), 64'(rd_stamp), 64'(vt[i].estamp));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].ecnt));
    end
    RegWriteW = 1'b0; rd_ready = 1'b0; cfg_mode = 2'd0;

    clr();
    cfg_wrap = 1'b0;
    for (int v = 1; v <= 6; v++) cap(32'(v));
    chk("nowrap_count", 64'(count), 64'd4);
    chk("nowrap_drop", 64'(dropped), 64'd2);
    drain("nowrap", 1, 4);

    clr();
    cfg_wrap = 1'b1;
    for (int v = 1; v <= 6; v++) cap(32'(v));
    chk("wrap_count", 64'(count), 64'd4);
    chk("wrap_drop", 64'(dropped), 64'd2);
    drain("wrap", 3, 4);

    clr();
    cfg_wrap = 1'b0;
    for (int v = 10; v <= 13; v++) cap(32'(v));
    chk("pp_full", 64'(count), 64'd4);
    rd_ready = 1'b1;
    cap(32'd14);
    rd_ready = 1'b0;
    chk("pp_count", 64'(count), 64'd4);
    chk("pp_drop", 64'(dropped), 64'd0);
    drain("pp", 11, 4);

    clr();
    StallF = 1'b1; FlushE = 1'b1;
    tick();
    tick();
    FlushE = 1'b0;
    tick();
    StallF = 1'b0;
    cap(32'd7);
    chk("ev_stall", 64'(stall_cnt), 64'd3);
    chk("ev_flush", 64'(flush_cnt), 64'd2);
    chk("ev_count", 64'(count), 64'd1);
    clear = 1'b1;
    cap(32'd9);
    clear = 1'b0;
    chk("clr_stall", 64'(stall_cnt), 64'd0);
    chk("clr_flush", 64'(flush_cnt), 64'd0);
    chk("clr_drop", 64'(dropped), 64'd0);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_valid", 64'(rd_valid), 64'd0);
    chk("clr_result", 64'(rd_result), 64'd0);
    tick();
    cap(32'd8);
    chk("post_clr_val", 64'(rd_result), 64'd8);
    chk("post_clr_stamp", 64'(rd_stamp), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
